load_store_ctrl: RTL and testbench
==================================

Name: load_store_ctrl

Overview:
- Load/store formatting unit between the execute stage and the word-addressed data memory.
- Store side: from func3, byte offset and the rs2 value, produces the lane-aligned write word and 4-bit byte-enable mask.
- Load side: decodes func3 into the memory's load-control code and extracts, then sign- or zero-extends, the addressed byte, halfword or word from the raw memory word.
- All outputs are registered; latency is one cycle.

Parameters:
- XLEN, 32, data width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- store_en  input  1  request is a store; gates the mask
- func3  input  3  RISC-V funct3 of the load/store
- address  input  2  byte offset, addr[1:0]
- rdata2  input  32  rs2 value to be stored
- rdata_mem  input  32  raw word read from data memory
- wdata_mem  output  32  lane-aligned store data
- mask  output  4  byte write enables; bit i covers bits [8i+7:8i]
- load_ctrl  output  3  load-control code
- load_data  output  32  extended load result

Behaviour:
- Outputs are registered on posedge clk and reflect the inputs of the previous cycle. No handshake.
- Reset: when rst=0 at a clock edge, next values are wdata_mem=0, mask=0000, load_ctrl=111, load_data=0. Reset overrides all inputs, including in mid-stream.
- load_ctrl decode from func3:
  - 000 (LB) -> 000
  - 001 (LH) -> 001
  - 010 (LW) -> 010
  - 100 (LBU) -> 011
  - 101 (LHU) -> 100
  - any other func3 -> 111 (invalid)
- Store, byte (func3=000): mask = 0001 << address; wdata_mem = {24'b0, rdata2[7:0]} << 8*address.
- Store, half (func3=001):
  - address[1]=0: mask=0011, wdata_mem={16'b0, rdata2[15:0]}.
  - address[1]=1: mask=1100, wdata_mem={rdata2[15:0], 16'b0}.
- Store, word (func3=010): mask=1111, wdata_mem=rdata2.
- Store, other func3: mask=0000, wdata_mem=rdata2.
- store_en=0 forces mask=0000. wdata_mem is still formatted.
- load_data:
  - LB/LBU: byte at lane address, sign-/zero-extended to 32 bits.
  - LH/LHU: half selected by address[1], sign-/zero-extended.
  - LW: rdata_mem unchanged.
  - Invalid code: 0.
- Misaligned access (halfword with address[0]=1, or word with address!=00): handling is defined in Optional Feature.

Optional Feature:
- Macro LS_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misaligned (1 bit, registered, reset 0), set for a misaligned access of any type.
  - For a misaligned store, mask is forced to 0000.
  - For a misaligned load, load_data is forced to 0.
- Undefined:
  - No misaligned port.
  - Low offset bits are ignored: halfword uses address[1] only; word ignores address.

Decomposition:
- Package ls_pkg holds:
  - func3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - load_ctrl enum: LC_LB=000, LC_LH=001, LC_LW=010, LC_LBU=011, LC_LHU=100, LC_INV=111.
- Sub-module ls_load_extract: combinational lane select plus extension, taking load_ctrl, address and rdata_mem. The top module keeps the store formatter and the output registers.

Test Plan:
- rst=0 for 2 cycles with random inputs -> mask=0000, load_ctrl=111, wdata_mem=0, load_data=0.
- SB: store_en=1, func3=000, address=10, rdata2=0x123456AB -> next cycle mask=0100, wdata_mem=0x00AB0000.
- SH: func3=001, address=10, rdata2=0xDEADBEEF -> mask=1100, wdata_mem=0xBEEF0000. Same stimulus with store_en=0 -> mask=0000.
- SW: func3=010, address=00, rdata2=0xCAFEF00D -> mask=1111, wdata_mem=0xCAFEF00D, load_ctrl=010.
- Loads with rdata_mem=0x80F17F01:
  - LB address=11 -> 0xFFFFFF80.
  - LBU address=11 -> 0x00000080.
  - LH address=10 -> 0xFFFF80F1.
  - LHU address=00 -> 0x00007F01.
  - func3=100 -> load_ctrl=011.
- Misaligned SW at address=01:
  - With LS_MISALIGN_TRAP_EN: misaligned=1, mask=0000.
  - Without: mask=1111.

Source files
------------

// File: rtl/ls_pkg.sv
// Shared func3 constants and load-control codes for the load/store unit.
// Used by load_store_ctrl and ls_load_extract.
package ls_pkg;

  localparam int DW = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    LC_LB  = 3'b000,
    LC_LH  = 3'b001,
    LC_LW  = 3'b010,
    LC_LBU = 3'b011,
    LC_LHU = 3'b100,
    LC_INV = 3'b111
  } lc_e;

  function automatic lc_e f3_to_lc(input logic [2:0] f3);
    case (f3)
      F3_B:    return LC_LB;
      F3_H:    return LC_LH;
      F3_W:    return LC_LW;
      F3_BU:   return LC_LBU;
      F3_HU:   return LC_LHU;
      default: return LC_INV;
    endcase
  endfunction

endpackage

// File: rtl/ls_load_extract.sv
// Load lane select and sign/zero extension of the raw memory word.
// Purely combinational; the top registers the result.
module ls_load_extract
  import ls_pkg::*;
(
  input  lc_e           load_ctrl_i,
  input  logic [1:0]    address_i,
  input  logic [DW-1:0] rdata_mem_i,
  output logic [DW-1:0] data_o
);

  logic [DW-1:0] sh;
  logic [7:0]    b;
  logic [15:0]   h;

  assign sh = rdata_mem_i >> {address_i, 3'b000};
  assign b  = sh[7:0];
  assign h  = address_i[1] ? rdata_mem_i[31:16]
                           : rdata_mem_i[15:0];

  // pick the lane and extend according to the load kind
  always_comb begin
    data_o = '0;
    case (load_ctrl_i)
      LC_LB:   data_o = {{24{b[7]}}, b};
      LC_LBU:  data_o = {24'b0, b};
      LC_LH:   data_o = {{16{h[15]}}, h};
      LC_LHU:  data_o = {16'b0, h};
      LC_LW:   data_o = rdata_mem_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_ctrl.sv
// Load/store formatter: store lane alignment, load decode/extract.
// Optional LS_MISALIGN_TRAP_EN adds a registered misaligned flag.
module load_store_ctrl
  import ls_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            store_en,
  input  logic [2:0]      func3,
  input  logic [1:0]      address,
  input  logic [XLEN-1:0] rdata2,
  input  logic [XLEN-1:0] rdata_mem,
  output logic [XLEN-1:0] wdata_mem,
  output logic [3:0]      mask,
`ifdef LS_MISALIGN_TRAP_EN
  output logic            misaligned,
`endif
  output logic [2:0]      load_ctrl,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] wdata_d, wdata_q;
  logic [3:0]      mask_d, mask_q;
  lc_e             lc_d, lc_q;
  logic [XLEN-1:0] ld_d, ld_q;
  logic [XLEN-1:0] ext;
  logic            mis_d;

  assign lc_d = f3_to_lc(func3);

  ls_load_extract u_ext (
    .load_ctrl_i (lc_d),
    .address_i   (address),
    .rdata_mem_i (rdata_mem),
    .data_o      (ext)
  );

  // halfword at odd offset, or word at any nonzero offset
  always_comb begin
    mis_d = 1'b0;
    case (lc_d)
      LC_LH, LC_LHU: mis_d = address[0];
      LC_LW:         mis_d = |address;
      default:       mis_d = 1'b0;
    endcase
  end

  // store formatting: lane-aligned data and byte enables
  always_comb begin
    wdata_d = rdata2;
    mask_d  = 4'b0000;
    case (func3)
      F3_B: begin
        mask_d  = 4'b0001 << address;
        wdata_d = {24'b0, rdata2[7:0]} << {address, 3'b000};
      end
      F3_H: begin
        if (address[1]) begin
          mask_d  = 4'b1100;
          wdata_d = {rdata2[15:0], 16'b0};
        end else begin
          mask_d  = 4'b0011;
          wdata_d = {16'b0, rdata2[15:0]};
        end
      end
      F3_W: begin
        mask_d  = 4'b1111;
        wdata_d = rdata2;
      end
      default: begin
        mask_d  = 4'b0000;
        wdata_d = rdata2;
      end
    endcase
    if (!store_en) mask_d = 4'b0000;
`ifdef LS_MISALIGN_TRAP_EN
    if (mis_d) mask_d = 4'b0000;
`endif
  end

  // load result, cleared on a trapped misaligned access
  always_comb begin
    ld_d = ext;
`ifdef LS_MISALIGN_TRAP_EN
    if (mis_d) ld_d = '0;
`endif
  end

  // output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdata_q <= '0;
      mask_q  <= 4'b0000;
      lc_q    <= LC_INV;
      ld_q    <= '0;
    end else begin
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      lc_q    <= lc_d;
      ld_q    <= ld_d;
    end
  end

`ifdef LS_MISALIGN_TRAP_EN
  logic mis_q;

  // registered misaligned flag
  always_ff @(posedge clk) begin
    if (!rst) mis_q <= 1'b0;
    else      mis_q <= mis_d;
  end

  assign misaligned = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_d;
`endif

  assign wdata_mem = wdata_q;
  assign mask      = mask_q;
  assign load_ctrl = lc_q;
  assign load_data = ld_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed self-checking bench for load_store_ctrl.
// Build with or without LS_MISALIGN_TRAP_EN.
module tb_load_store_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        store_en;
  logic [2:0]  func3;
  logic [1:0]  address;
  logic [31:0] rdata2;
  logic [31:0] rdata_mem;
  logic [31:0] wdata_mem;
  logic [3:0]  mask;
  logic [2:0]  load_ctrl;
  logic [31:0] load_data;
`ifdef LS_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  load_store_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .store_en  (store_en),
    .func3     (func3),
    .address   (address),
    .rdata2    (rdata2),
    .rdata_mem (rdata_mem),
    .wdata_mem (wdata_mem),
    .mask      (mask),
`ifdef LS_MISALIGN_TRAP_EN
    .misaligned(misaligned),
`endif
    .load_ctrl (load_ctrl),
    .load_data (load_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic se,
                       input logic [2:0] f3, input logic [1:0] a,
                       input logic [31:0] d2, input logic [31:0] dm);
    rst = r; store_en = se; func3 = f3;
    address = a; rdata2 = d2; rdata_mem = dm;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; store_en = 1'b0; func3 = '0;
    address = '0; rdata2 = '0; rdata_mem = '0;

    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'($urandom), 3'($urandom), 2'($urandom),
            $urandom, $urandom);
      chk("rst_mask", {28'b0, mask}, 32'h0);
      chk("rst_lc", {29'b0, load_ctrl}, 32'h7);
      chk("rst_wdata", wdata_mem, 32'h0);
      chk("rst_ldata", load_data, 32'h0);
`ifdef LS_MISALIGN_TRAP_EN
      chk("rst_mis", {31'b0, misaligned}, 32'h0);
`endif
    end

    drive(1'b1, 1'b1, 3'b000, 2'b10, 32'h123456AB, 32'h0);
    chk("sb_mask", {28'b0, mask}, 32'h4);
    chk("sb_wdata", wdata_mem, 32'h00AB0000);
    chk("sb_lc", {29'b0, load_ctrl}, 32'h0);

    drive(1'b1, 1'b1, 3'b001, 2'b10, 32'hDEADBEEF, 32'h0);
    chk("sh_mask", {28'b0, mask}, 32'hC);
    chk("sh_wdata", wdata_mem, 32'hBEEF0000);

    drive(1'b1, 1'b0, 3'b001, 2'b10, 32'hDEADBEEF, 32'h0);
    chk("sh_noen_mask", {28'b0, mask}, 32'h0);
    chk("sh_noen_wdata", wdata_mem, 32'hBEEF0000);

    drive(1'b1, 1'b1, 3'b001, 2'b00, 32'hDEADBEEF, 32'h0);
    chk("sh_lo_mask", {28'b0, mask}, 32'h3);
    chk("sh_lo_wdata", wdata_mem, 32'h0000BEEF);

    drive(1'b1, 1'b1, 3'b010, 2'b00, 32'hCAFEF00D, 32'h0);
    chk("sw_mask", {28'b0, mask}, 32'hF);
    chk("sw_wdata", wdata_mem, 32'hCAFEF00D);
    chk("sw_lc", {29'b0, load_ctrl}, 32'h2);

    drive(1'b1, 1'b1, 3'b011, 2'b00, 32'h11223344, 32'h0);
    chk("inv_mask", {28'b0, mask}, 32'h0);
    chk("inv_wdata", wdata_mem, 32'h11223344);
    chk("inv_lc", {29'b0, load_ctrl}, 32'h7);

    drive(1'b1, 1'b0, 3'b000, 2'b11, 32'h0, 32'h80F17F01);
    chk("lb3", load_data, 32'hFFFFFF80);
    drive(1'b1, 1'b0, 3'b000, 2'b01, 32'h0, 32'h80F17F01);
    chk("lb1", load_data, 32'h0000007F);
    drive(1'b1, 1'b0, 3'b100, 2'b11, 32'h0, 32'h80F17F01);
    chk("lbu3", load_data, 32'h00000080);
    chk("lbu_lc", {29'b0, load_ctrl}, 32'h3);
    drive(1'b1, 1'b0, 3'b001, 2'b10, 32'h0, 32'h80F17F01);
    chk("lh2", load_data, 32'hFFFF80F1);
    chk("lh_lc", {29'b0, load_ctrl}, 32'h1);
    drive(1'b1, 1'b0, 3'b101, 2'b00, 32'h0, 32'h80F17F01);
    chk("lhu0", load_data, 32'h00007F01);
    chk("lhu_lc", {29'b0, load_ctrl}, 32'h4);
    drive(1'b1, 1'b0, 3'b010, 2'b00, 32'h0, 32'h80F17F01);
    chk("lw", load_data, 32'h80F17F01);
    drive(1'b1, 1'b0, 3'b110, 2'b00, 32'h0, 32'h80F17F01);
    chk("linv", load_data, 32'h0);
    chk("linv_lc", {29'b0, load_ctrl}, 32'h7);

    drive(1'b1, 1'b1, 3'b010, 2'b01, 32'hA5A5A5A5, 32'h80F17F01);
`ifdef LS_MISALIGN_TRAP_EN
    chk("msw_mis", {31'b0, misaligned}, 32'h1);
    chk("msw_mask", {28'b0, mask}, 32'h0);
    chk("msw_ldata", load_data, 32'h0);
`else
    chk("msw_mask", {28'b0, mask}, 32'hF);
    chk("msw_ldata", load_data, 32'h80F17F01);
`endif

    drive(1'b1, 1'b0, 3'b001, 2'b11, 32'h0, 32'h80F17F01);
`ifdef LS_MISALIGN_TRAP_EN
    chk("mlh_mis", {31'b0, misaligned}, 32'h1);
    chk("mlh_ldata", load_data, 32'h0);
`else
    chk("mlh_ldata", load_data, 32'hFFFF80F1);
`endif

    drive(1'b0, 1'b1, 3'b010, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mrst_mask", {28'b0, mask}, 32'h0);
    chk("mrst_lc", {29'b0, load_ctrl}, 32'h7);
    chk("mrst_wdata", wdata_mem, 32'h0);
    chk("mrst_ldata", load_data, 32'h0);

    drive(1'b1, 1'b1, 3'b000, 2'b00, 32'h000000C3, 32'h0);
    chk("sb0_mask", {28'b0, mask}, 32'h1);
    chk("sb0_wdata", wdata_mem, 32'h000000C3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
